// File: rtl/sync_block_pkg.sv
// Shared sizes and channel indices for the external-signal conditioning path.
// Channel bit order: start, fast-gate opto, phase, wire sensor, detector ready.
package sync_block_pkg;

    localparam int CHANNELS     = 5;
    localparam int FILTER_WIDTH = 8;
    localparam int PERIOD_WIDTH = 32;

    typedef enum logic [2:0] {
        CH_START     = 3'd0,
        CH_FG        = 3'd1,
        CH_PHASE     = 3'd2,
        CH_WIRE      = 3'd3,
        CH_DET_READY = 3'd4
    } ch_idx_e;

endpackage

// File: rtl/input_filter_channel.sv
// One conditioned input: two-flop synchronizer, glitch filter, level and edge strobes.
// A stable raw change reaches level (and its strobe) N+2 edges after first sampling.
module input_filter_channel #(
    parameter int   FILTER_WIDTH = sync_block_pkg::FILTER_WIDTH,
    parameter logic LEVEL_INIT   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    raw,
    input  logic [FILTER_WIDTH-1:0] filter_len,
    output logic                    level,
    output logic                    rise,
    output logic                    fall
);

    logic                    sync1;
    logic                    sync2;
    logic [FILTER_WIDTH-1:0] cnt;
    logic [FILTER_WIDTH:0]   cnt_inc;
    logic [FILTER_WIDTH:0]   n_eff;
    logic                    flip;

    // One extra bit so counter+1 never wraps before the compare.
    assign cnt_inc = {1'b0, cnt} + 1'b1;
    assign n_eff   = (filter_len == '0) ? (FILTER_WIDTH+1)'(1) : {1'b0, filter_len};
    assign flip    = (sync2 != level) && (cnt_inc >= n_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= LEVEL_INIT;
            sync2 <= LEVEL_INIT;
            level <= LEVEL_INIT;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= flip && !level;
            fall  <= flip && level;
            if (sync2 == level || flip) begin
                cnt <= '0;
            end else begin
                cnt <= cnt_inc[FILTER_WIDTH-1:0];
            end
            if (flip) begin
                level <= ~level;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Conditions the external inputs and measures the period between filtered phase rises.
// Period/valid update one cycle after the phase rise strobe; a watchdog flags lost phase.
module input_conditioner #(
    parameter int                  CHANNELS     = sync_block_pkg::CHANNELS,
    parameter int                  FILTER_WIDTH = sync_block_pkg::FILTER_WIDTH,
    parameter int                  PERIOD_WIDTH = sync_block_pkg::PERIOD_WIDTH,
    parameter logic [CHANNELS-1:0] LEVEL_INIT   = 5'b10000
) (
    input  logic                    clock_reg_input,
    input  logic                    reset_reg_input,
    input  logic [CHANNELS-1:0]     raw_reg_input,
    input  logic [FILTER_WIDTH-1:0] filter_len_reg_input,
    input  logic [PERIOD_WIDTH-1:0] phase_timeout_reg_input,
    input  logic                    clear_reg_input,
    output logic [CHANNELS-1:0]     level_reg_output,
    output logic [CHANNELS-1:0]     rise_reg_output,
    output logic [CHANNELS-1:0]     fall_reg_output,
    output logic [PERIOD_WIDTH-1:0] phase_period_reg_output,
    output logic                    phase_valid_reg_output,
    output logic                    phase_lost_reg_output
);

    localparam int PHASE_IDX = int'(sync_block_pkg::CH_PHASE);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        input_filter_channel #(
            .FILTER_WIDTH (FILTER_WIDTH),
            .LEVEL_INIT   (LEVEL_INIT[i])
        ) u_ch (
            .clk        (clock_reg_input),
            .rst_n      (reset_reg_input),
            .raw        (raw_reg_input[i]),
            .filter_len (filter_len_reg_input),
            .level      (level_reg_output[i]),
            .rise       (rise_reg_output[i]),
            .fall       (fall_reg_output[i])
        );
    end

    logic [PERIOD_WIDTH-1:0] phase_cnt;
    logic [PERIOD_WIDTH-1:0] phase_cnt_next;
    logic                    phase_armed;
    logic                    phase_rise;

    assign phase_rise     = rise_reg_output[PHASE_IDX];
    assign phase_cnt_next = (phase_cnt == '1) ? phase_cnt : phase_cnt + PERIOD_WIDTH'(1);

    always_ff @(posedge clock_reg_input or negedge reset_reg_input) begin
        if (!reset_reg_input) begin
            phase_cnt               <= '0;
            phase_armed             <= 1'b0;
            phase_period_reg_output <= '0;
            phase_valid_reg_output  <= 1'b0;
            phase_lost_reg_output   <= 1'b0;
        end else if (clear_reg_input) begin
            phase_cnt               <= '0;
            phase_armed             <= 1'b0;
            phase_period_reg_output <= '0;
            phase_valid_reg_output  <= 1'b0;
            phase_lost_reg_output   <= 1'b0;
        end else if (phase_rise) begin
            // Expiry disarms, so an armed rise implies no timeout since the previous one.
            if (phase_armed) begin
                phase_period_reg_output <= phase_cnt;
                phase_valid_reg_output  <= 1'b1;
            end
            phase_cnt             <= PERIOD_WIDTH'(1);
            phase_armed           <= 1'b1;
            phase_lost_reg_output <= 1'b0;
        end else begin
            phase_cnt <= phase_cnt_next;
            if (phase_timeout_reg_input != '0 && phase_cnt_next == phase_timeout_reg_input) begin
                phase_lost_reg_output  <= 1'b1;
                phase_valid_reg_output <= 1'b0;
                phase_armed            <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a timestamp/history reference model.
module tb_input_conditioner;

    localparam int         CH   = 5;
    localparam int         FW   = 8;
    localparam int         PW   = 32;
    localparam int         HL   = 300;
    localparam logic [4:0] INIT = 5'b10000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] raw = INIT;
    logic [FW-1:0] flen = 8'd4;
    logic [PW-1:0] tmo = '0;
    logic          clr = 1'b0;
    logic [CH-1:0] lvl_o, rise_o, fall_o;
    logic [PW-1:0] per_o;
    logic          val_o, lost_o;

    input_conditioner dut (
        .clock_reg_input         (clk),
        .reset_reg_input         (rst_n),
        .raw_reg_input           (raw),
        .filter_len_reg_input    (flen),
        .phase_timeout_reg_input (tmo),
        .clear_reg_input         (clr),
        .level_reg_output        (lvl_o),
        .rise_reg_output         (rise_o),
        .fall_reg_output         (fall_o),
        .phase_period_reg_output (per_o),
        .phase_valid_reg_output  (val_o),
        .phase_lost_reg_output   (lost_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: synchronized samples kept as a history; a level flips once the
    // most recent max(N,1) synchronized samples all disagree with it.
    bit            hist [CH][HL];
    int            hist_n [CH];
    logic [CH-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
    longint        t, base;
    logic [PW-1:0] m_per;
    logic          m_val, m_lost, m_arm;

    always @(posedge clk) begin
        logic          p_rise;
        logic [CH-1:0] raw_s;
        int            neff, run;
        longint        cnt;
        raw_s = raw;
        if (!rst_n) begin
            m_s1 = INIT; m_s2 = INIT; m_lvl = INIT; m_rise = '0; m_fall = '0;
            for (int c = 0; c < CH; c++) hist_n[c] = 0;
            base = t; m_per = '0; m_val = 0; m_lost = 0; m_arm = 0;
        end else begin
            t++;
            p_rise = m_rise[2];
            if (clr) begin
                base = t; m_per = '0; m_val = 0; m_lost = 0; m_arm = 0;
            end else if (p_rise) begin
                if (m_arm) begin
                    m_per = PW'(t - 1 - base);
                    m_val = 1;
                end
                m_arm = 1; m_lost = 0; base = t - 1;
            end else begin
                cnt = t - base;
                if (cnt > 64'hFFFF_FFFF) cnt = 64'hFFFF_FFFF;
                if (tmo != 0 && cnt == longint'(tmo)) begin
                    m_lost = 1; m_val = 0; m_arm = 0;
                end
            end
            neff = (flen == 0) ? 1 : int'(flen);
            for (int c = 0; c < CH; c++) begin
                for (int k = HL - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = m_s2[c];
                if (hist_n[c] < HL) hist_n[c]++;
                m_s2[c] = m_s1[c];
                m_s1[c] = raw_s[c];
                run = 0;
                for (int k = 0; k < hist_n[c] && run < neff; k++) begin
                    if (hist[c][k] == m_lvl[c]) break;
                    run++;
                end
                m_rise[c] = 0; m_fall[c] = 0;
                if (run >= neff) begin
                    m_rise[c] = !m_lvl[c];
                    m_fall[c] = m_lvl[c];
                    m_lvl[c]  = !m_lvl[c];
                end
            end
        end
        #1;
        check("model_level", lvl_o, m_lvl);
        check("model_rise", rise_o, m_rise);
        check("model_fall", fall_o, m_fall);
        check("model_period", per_o, m_per);
        check("model_valid", val_o, m_val);
        check("model_lost", lost_o, m_lost);
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic phase_pulse();
        raw[2] = 1'b1;
        wait_neg(20);
        raw[2] = 1'b0;
    endtask

    initial begin
        logic acc;
        logic found;
        t = 0;
        base = 0;
        wait_neg(3);
        check("reset_level", lvl_o, INIT);
        check("reset_strobes", {rise_o, fall_o}, '0);
        check("reset_phase", {per_o, val_o, lost_o}, '0);
        rst_n = 1'b1;
        wait_neg(5);

        // Start channel, N=4: level flips on edge 6 with a single-cycle rise.
        raw[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("start_level_e5", lvl_o[0], 1'b0);
        @(posedge clk);
        #1 check("start_level_e6", lvl_o[0], 1'b1);
        check("start_rise_e6", rise_o[0], 1'b1);
        @(posedge clk);
        #1 check("start_rise_e7", rise_o[0], 1'b0);
        @(negedge clk) raw[0] = 1'b0;
        wait_neg(10);

        // Wire sensor glitch of 3 cycles is rejected.
        raw[3] = 1'b1;
        wait_neg(3);
        raw[3] = 1'b0;
        acc = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1 acc = acc | lvl_o[3] | rise_o[3] | fall_o[3];
        end
        check("wire_glitch", acc, 1'b0);

        // N=0 behaves as N=1: flip on edge 3.
        @(negedge clk);
        flen = 8'd0;
        raw[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("n0_level_e2", lvl_o[1], 1'b0);
        @(posedge clk);
        #1 check("n0_level_e3", lvl_o[1], 1'b1);
        @(negedge clk);
        flen = 8'd4;
        raw[1] = 1'b0;
        wait_neg(10);

        // Lowering N mid-count flips on the next differing cycle.
        flen = 8'd8;
        raw[1] = 1'b1;
        wait_neg(5);
        flen = 8'd2;
        wait_neg(10);
        raw[1] = 1'b0;
        flen = 8'd4;
        wait_neg(15);

        // Phase period, watchdog disabled.
        clr = 1'b1;
        wait_neg(1);
        clr = 1'b0;
        tmo = '0;
        phase_pulse();
        check("phase_first_valid", val_o, 1'b0);
        wait_neg(80);
        phase_pulse();
        check("phase_period_100", per_o, 32'd100);
        check("phase_valid_2nd", val_o, 1'b1);
        wait_neg(80);

        // Watchdog 150 after phase stops.
        tmo = 32'd150;
        wait_neg(40);
        check("wd_not_yet", {val_o, lost_o}, 2'b10);
        wait_neg(30);
        check("wd_lost", {val_o, lost_o}, 2'b01);
        check("wd_period_held", per_o, 32'd100);
        phase_pulse();
        check("wd_rearm", {val_o, lost_o}, 2'b00);
        wait_neg(80);
        phase_pulse();
        check("wd_valid_again", val_o, 1'b1);
        check("wd_period", per_o, 32'd100);
        wait_neg(60);

        // Clear in the same cycle as a phase rise.
        tmo = '0;
        raw[2] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1 if (rise_o[2]) found = 1'b1;
        end
        check("clr_rise_seen", found, 1'b1);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("clr_period", per_o, 32'd0);
        check("clr_valid", val_o, 1'b0);
        wait_neg(10);
        raw[2] = 1'b0;
        wait_neg(70);
        phase_pulse();
        check("clr_arm_only", val_o, 1'b0);
        wait_neg(80);
        phase_pulse();
        check("clr_valid_back", val_o, 1'b1);
        check("clr_period_100", per_o, 32'd100);
        wait_neg(10);

        // Reset mid-filter on detector_ready.
        raw[4] = 1'b0;
        wait_neg(4);
        rst_n = 1'b0;
        #1 check("rst_det_level", lvl_o[4], 1'b1);
        check("rst_det_fall", fall_o[4], 1'b0);
        wait_neg(2);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("det_level_e5", lvl_o[4], 1'b1);
        @(posedge clk);
        #1 check("det_fall_e6", {lvl_o[4], fall_o[4]}, 2'b01);
        @(posedge clk);
        #1 check("det_fall_e7", fall_o[4], 1'b0);
        wait_neg(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter CHANNELS, default 5, number of conditioned inputs; bit order 0 start, 1 fast_gate_opto, 2 phase, 3 wire_sensor, 4 detector_ready.
REQ-002 Parameter FILTER_WIDTH, default 8, width of the glitch-filter length and counters.
REQ-003 Parameter PERIOD_WIDTH, default 32, width of the phase period counter, period output and timeout.
REQ-004 Parameter LEVEL_INIT, default 5'b10000, reset value of the sync flops and filtered levels per channel; detector_ready idles high.
REQ-005 clock_reg_input  in  1  single system clock; all logic on its rising edge.
REQ-006 reset_reg_input  in  1  asynchronous, active-low reset.
REQ-007 raw_reg_input  in  CHANNELS  unsynchronized external signals.
REQ-008 filter_len_reg_input  in  FILTER_WIDTH  required stable cycles N; value 0 is treated as N=1.
REQ-009 phase_timeout_reg_input  in  PERIOD_WIDTH  phase watchdog limit in cycles; 0 disables the watchdog.
REQ-010 clear_reg_input  in  1  synchronous clear of the phase measurement.
REQ-011 level_reg_output  out  CHANNELS  filtered levels, consumed by scenario_multiplexer.
REQ-012 rise_reg_output  out  CHANNELS  one-cycle strobe on filtered 0->1.
REQ-013 fall_reg_output  out  CHANNELS  one-cycle strobe on filtered 1->0.
REQ-014 phase_period_reg_output  out  PERIOD_WIDTH  cycles between the last two phase rises.
REQ-015 phase_valid_reg_output  out  1  phase_period holds a valid measurement.
REQ-016 phase_lost_reg_output  out  1  watchdog expired since the last phase rise.

Function
REQ-017 Each channel SHALL pass through a two-flop synchronizer; the edge sampling the new raw value counts as edge 1 and the second flop updates on edge 2.
REQ-018 Per-channel counter SHALL increment each cycle the synchronized value differs from level, and SHALL clear to 0 the first cycle they are equal.
REQ-019 Level SHALL toggle, and the counter SHALL clear, on the edge where the counter would reach N; a stable raw change therefore appears on level at edge N+2.
REQ-020 Pulses shorter than N synchronized cycles SHALL never change level or produce strobes.
REQ-021 rise/fall SHALL be registered, asserted in exactly the cycle level changes, high for one cycle; rise and fall of one channel SHALL never assert together.
REQ-022 A filter_len change SHALL take effect immediately; the comparison is counter+1 >= N, so a lowered N flips on the next differing cycle.
REQ-023 Phase counter SHALL increment every cycle, saturate at all-ones, and restart at 1 on each rise_reg_output[2].
REQ-024 On a phase rise with an armed measurement and no watchdog expiry since the previous rise, phase_period SHALL load the counter value and phase_valid SHALL set, both in the cycle after the strobe.
REQ-025 The first phase rise after reset, clear or watchdog expiry SHALL only arm the measurement: no period load, phase_valid stays 0.
REQ-026 When the timeout is nonzero and the counter reaches it, phase_lost SHALL set and phase_valid SHALL clear; phase_period holds its last value.
REQ-027 phase_lost SHALL clear on the next phase rise.
REQ-028 clear_reg_input SHALL zero the period, valid, lost, counter and arm state; clear wins over a simultaneous phase rise.
REQ-029 Saturation with the watchdog disabled SHALL hold the counter at all-ones; the next rise loads all-ones as the period.

Reset
REQ-030 While reset_reg_input=0, sync flops and level SHALL equal LEVEL_INIT, and strobes, counters, period, valid, lost and arm SHALL be 0.
REQ-031 No rise/fall strobe SHALL be generated by reset assertion or release.
REQ-032 Reset mid-filter SHALL discard any partial count.

Structure
REQ-033 Package sync_block_pkg SHALL hold the channel-index enum (CH_START, CH_FG, CH_PHASE, CH_WIRE, CH_DET_READY), CHANNELS, FILTER_WIDTH and PERIOD_WIDTH.
REQ-034 Sub-module input_filter_channel (synchronizer, filter counter, level, strobes) SHALL be instantiated CHANNELS times; phase measurement stays in the top.

Verification
REQ-035 N=4, raw[0] 0->1 held: level[0] rises at edge 6 after the first sampling edge, and rise[0] is high for exactly that cycle.
REQ-036 N=4, raw[3] high for 3 cycles, then low: level, rise and fall remain 0.
REQ-037 Phase rises every 100 cycles, timeout 0: after the 2nd rise, period=100 and valid=1; after the 1st rise, valid=0.
REQ-038 Timeout 150, phase stops after valid: lost=1 and valid=0 at count 150; the next rise clears lost, and the rise after that gives valid=1.
REQ-039 Clear asserted in the cycle of a phase rise: period=0 and valid=0; valid returns only after two further rises.
REQ-040 Reset asserted mid-count with raw[4]=0: level[4]=1 immediately; after release, fall[4] pulses once at edge N+2.
